// File: rtl/game_pkg.sv
// Shared geometry defaults, game state enum and palette for the pong pixel stage.
package game_pkg;

    localparam int DEF_CLK_PER_PIX = 4;
    localparam int DEF_H_PIX       = 640;
    localparam int DEF_V_PIX       = 480;
    localparam int DEF_BALL_SZ     = 8;
    localparam int DEF_PAD_X       = 8;
    localparam int DEF_PAD_W       = 8;
    localparam int DEF_PAD_H       = 64;
    localparam int DEF_BALL_STEP   = 2;
    localparam int DEF_PAD_STEP    = 4;
    localparam int DEF_MISS_FRAMES = 30;

    // Wide enough for hc / CLK_PER_PIX, so screen coordinates and counters share one type.
    typedef logic [12:0] pix_t;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        MISS  = 2'd2
    } game_state_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } colour_t;

    localparam colour_t BALL_C = {3'd7, 3'd7, 2'd3};
    localparam colour_t PAD_C  = {3'd0, 3'd7, 2'd0};
    localparam colour_t BG_C   = {3'd0, 3'd0, 2'd0};
    localparam colour_t MISS_C = {3'd7, 3'd0, 2'd0};

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous button; EDGE=1 turns the output into a one-clock rising-edge pulse.
module btn_sync #(
    parameter bit EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q
);

    logic [1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], din};
        end
    end

    generate
        if (EDGE) begin : g_edge
            logic last;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    last <= 1'b0;
                end else begin
                    last <= sync[1];
                end
            end

            assign q = sync[1] & ~last;
        end else begin : g_level
            assign q = sync[1];
        end
    endgenerate

endmodule

// File: rtl/pong_renderer.sv
// One-ball/one-paddle pong: game state advances once per frame in vertical blanking, active pixel painted one clock after hc/vc.
// Define AUTOPLAY_EN to make the paddle chase the ball and ignore btn_up/btn_down.
module pong_renderer
    import game_pkg::*;
#(
    parameter int CLK_PER_PIX = DEF_CLK_PER_PIX,
    parameter int H_PIX       = DEF_H_PIX,
    parameter int V_PIX       = DEF_V_PIX,
    parameter int BALL_SZ     = DEF_BALL_SZ,
    parameter int PAD_X       = DEF_PAD_X,
    parameter int PAD_W       = DEF_PAD_W,
    parameter int PAD_H       = DEF_PAD_H,
    parameter int BALL_STEP   = DEF_BALL_STEP,
    parameter int PAD_STEP    = DEF_PAD_STEP,
    parameter int MISS_FRAMES = DEF_MISS_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] hc,
    input  logic [10:0] vc,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_serve,
    output logic [2:0]  rout,
    output logic [2:0]  gout,
    output logic [1:0]  bout,
    output logic [7:0]  hits
);

    localparam int   MCW       = $clog2(MISS_FRAMES + 1);
    localparam pix_t HV        = pix_t'(H_PIX);
    localparam pix_t VV        = pix_t'(V_PIX);
    localparam pix_t BSZ       = pix_t'(BALL_SZ);
    localparam pix_t BSTEP     = pix_t'(BALL_STEP);
    localparam pix_t PSTEP     = pix_t'(PAD_STEP);
    localparam pix_t PH        = pix_t'(PAD_H);
    localparam pix_t PX0       = pix_t'(PAD_X);
    localparam pix_t PAD_FACE  = pix_t'(PAD_X + PAD_W);
    localparam pix_t X_MAX     = pix_t'(H_PIX - BALL_SZ);
    localparam pix_t Y_MAX     = pix_t'(V_PIX - BALL_SZ);
    localparam pix_t X_TURN    = pix_t'(H_PIX - BALL_SZ - BALL_STEP);
    localparam pix_t Y_TURN    = pix_t'(V_PIX - BALL_SZ - BALL_STEP);
    localparam pix_t X_START   = pix_t'((H_PIX - BALL_SZ) / 2);
    localparam pix_t Y_START   = pix_t'((V_PIX - BALL_SZ) / 2);
    localparam pix_t PAD_MAX   = pix_t'(V_PIX - PAD_H);
    localparam pix_t PAD_START = pix_t'((V_PIX - PAD_H) / 2);

    game_state_t    state_q, state_d;
    pix_t           bx, by, pad_y;
    logic           dx_neg, dy_neg;
    logic [7:0]     hits_q;
    logic [MCW-1:0] miss_cnt;
    logic           serve_pend, serve_rise, serve_go;
    logic           frame_tick;
    logic           ball_live, restart;
    colour_t        bg_c;

    logic           ndx_neg, ndy_neg, hit, miss, overlap;
    pix_t           nbx, nby, pad_next;
    logic           up_req, down_req;

    btn_sync #(.EDGE(1'b1)) u_serve (.clk(clk), .rst(rst), .din(btn_serve), .q(serve_rise));

`ifdef AUTOPLAY_EN
    // Steer the paddle centre toward the ball centre.
    assign up_req   = (pad_y + PH / 2) > (by + BSZ / 2);
    assign down_req = (pad_y + PH / 2) < (by + BSZ / 2);
`else
    logic up_lvl, down_lvl;

    btn_sync #(.EDGE(1'b0)) u_up   (.clk(clk), .rst(rst), .din(btn_up),   .q(up_lvl));
    btn_sync #(.EDGE(1'b0)) u_down (.clk(clk), .rst(rst), .din(btn_down), .q(down_lvl));

    assign up_req   = up_lvl & ~down_lvl;
    assign down_req = down_lvl & ~up_lvl;
`endif

    assign frame_tick = (hc == 13'd0) && (vc == 11'(V_PIX));
    assign serve_go   = serve_pend | serve_rise;

    // A serve press is remembered until the next frame boundary consumes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            serve_pend <= 1'b0;
        end else begin
            serve_pend <= (state_q == SERVE) && !frame_tick && serve_go;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SERVE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (frame_tick) begin
            case (state_q)
                SERVE:   if (serve_go) state_d = PLAY;
                PLAY:    if (miss) state_d = MISS;
                MISS:    if (miss_cnt == '0) state_d = SERVE;
                default: state_d = SERVE;
            endcase
        end
    end

    always_comb begin
        ball_live = 1'b0;
        restart   = 1'b0;
        bg_c      = BG_C;
        case (state_q)
            SERVE: ball_live = serve_go;
            PLAY:  ball_live = 1'b1;
            MISS: begin
                bg_c    = MISS_C;
                restart = (miss_cnt == '0);
            end
            default: restart = 1'b1;
        endcase
    end

    // Bounce/hit/miss resolution, then a clamped step along the resolved direction.
    always_comb begin
        ndx_neg = dx_neg;
        ndy_neg = dy_neg;
        hit     = 1'b0;
        miss    = 1'b0;
        overlap = (by + BSZ > pad_y) && (by < pad_y + PH);
        if (by <= BSTEP) begin
            ndy_neg = 1'b0;
        end else if (by >= Y_TURN) begin
            ndy_neg = 1'b1;
        end
        if (bx >= X_TURN) begin
            ndx_neg = 1'b1;
        end else if (dx_neg && (bx <= PAD_FACE) && overlap) begin
            ndx_neg = 1'b0;
            hit     = 1'b1;
        end else if (dx_neg && (bx <= BSTEP)) begin
            miss = 1'b1;
        end
        if (ndx_neg) begin
            nbx = (bx < BSTEP) ? '0 : bx - BSTEP;
        end else begin
            nbx = (bx > X_MAX - BSTEP) ? X_MAX : bx + BSTEP;
        end
        if (ndy_neg) begin
            nby = (by < BSTEP) ? '0 : by - BSTEP;
        end else begin
            nby = (by > Y_MAX - BSTEP) ? Y_MAX : by + BSTEP;
        end
    end

    always_comb begin
        pad_next = pad_y;
        if (up_req) begin
            pad_next = (pad_y < PSTEP) ? '0 : pad_y - PSTEP;
        end else if (down_req) begin
            pad_next = (pad_y > PAD_MAX - PSTEP) ? PAD_MAX : pad_y + PSTEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bx       <= X_START;
            by       <= Y_START;
            dx_neg   <= 1'b0;
            dy_neg   <= 1'b0;
            pad_y    <= PAD_START;
            hits_q   <= 8'd0;
            miss_cnt <= '0;
        end else if (frame_tick) begin
            pad_y <= pad_next;
            if (restart) begin
                bx     <= X_START;
                by     <= Y_START;
                dx_neg <= 1'b0;
                dy_neg <= 1'b0;
                hits_q <= 8'd0;
            end else if (ball_live) begin
                if (miss) begin
                    miss_cnt <= MCW'(MISS_FRAMES - 1);
                end else begin
                    bx     <= nbx;
                    by     <= nby;
                    dx_neg <= ndx_neg;
                    dy_neg <= ndy_neg;
                end
                if (hit && (hits_q != 8'hFF)) begin
                    hits_q <= hits_q + 8'd1;
                end
            end else if (state_q == MISS) begin
                miss_cnt <= miss_cnt - 1'b1;
            end
        end
    end

    pix_t    px, py;
    logic    visible, on_ball, on_pad;
    colour_t pix_d, pix_q;

    assign px      = hc / pix_t'(CLK_PER_PIX);
    assign py      = pix_t'(vc);
    assign visible = (px < HV) && (py < VV);
    assign on_ball = (px >= bx) && (px < bx + BSZ) && (py >= by) && (py < by + BSZ);
    assign on_pad  = (px >= PX0) && (px < PAD_FACE) && (py >= pad_y) && (py < pad_y + PH);

    always_comb begin
        pix_d = BG_C;
        if (visible) begin
            if (on_ball) begin
                pix_d = BALL_C;
            end else if (on_pad) begin
                pix_d = PAD_C;
            end else begin
                pix_d = bg_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q <= BG_C;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign rout = pix_q.r;
    assign gout = pix_q.g;
    assign bout = pix_q.b;
    assign hits = hits_q;

endmodule

// File: tb/tb_pong_renderer.sv
// Directed bench for pong_renderer: drives hc/vc directly (frame boundaries and single-pixel probes) and scoreboards {hits, rgb}.
module tb_pong_renderer;

    localparam logic [7:0] WHITE = 8'hFF;
    localparam logic [7:0] GREEN = 8'h1C;
    localparam logic [7:0] RED   = 8'hE0;
    localparam logic [7:0] BLACK = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] hc;
    logic [10:0] vc;
    logic        btn_up, btn_down, btn_serve;
    logic [2:0]  rout, gout;
    logic [1:0]  bout;
    logic [7:0]  hits;

    pong_renderer dut (
        .clk(clk), .rst(rst), .hc(hc), .vc(vc),
        .btn_up(btn_up), .btn_down(btn_down), .btn_serve(btn_serve),
        .rout(rout), .gout(gout), .bout(bout), .hits(hits)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    string       name_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          ticks = 0;
    logic        probe_v = 1'b0;
    logic        probe_q = 1'b0;
    logic [15:0] mon_exp;
    string       mon_name;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got hits=%0d rgb=%h, expected hits=%0d rgb=%h",
                     nm, act[15:8], act[7:0], exp[15:8], exp[7:0]);
        end
    endtask

    // A probe's pixel is registered one clock after hc/vc are presented.
    always @(posedge clk) probe_q <= probe_v;

    always @(negedge clk) begin
        if (probe_q) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got rgb=%h with no expectation queued", {rout, gout, bout});
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                check(mon_name, {hits, rout, gout, bout}, mon_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic probe(input string nm, input int x, input int y, input logic [7:0] rgb, input int h);
        @(negedge clk);
        hc      = 13'(x * 4);
        vc      = 11'(y);
        probe_v = 1'b1;
        exp_q.push_back({8'(h), rgb});
        name_q.push_back(nm);
        @(negedge clk);
        probe_v = 1'b0;
        hc      = 13'd0;
        vc      = 11'd500;
    endtask

    task automatic check_ball(input string tag, input int x, input int y, input logic [7:0] bg, input int h);
        probe({tag, "_tl"}, x, y, WHITE, h);
        probe({tag, "_br"}, x + 7, y + 7, WHITE, h);
        probe({tag, "_right"}, x + 8, y, bg, h);
        probe({tag, "_above"}, x, y - 1, bg, h);
    endtask

    task automatic tick();
        repeat (3) @(negedge clk);
        hc = 13'd0;
        vc = 11'd480;
        @(negedge clk);
        vc = 11'd500;
        ticks++;
    endtask

    task automatic run_to(input int n);
        while (ticks < n) tick();
    endtask

    task automatic press_serve();
        @(negedge clk);
        btn_serve = 1'b1;
        repeat (3) @(negedge clk);
        btn_serve = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; hc = 13'd0; vc = 11'd500;
        btn_up = 1'b0; btn_down = 1'b0; btn_serve = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {hits, rout, gout, bout}, 16'h0000);
        rst = 1'b0;

        // Reset state: ball centred, paddle at 208, screen edges.
        check_ball("init", 316, 236, BLACK, 0);
        probe("pad_top",       8, 208, GREEN, 0);
        probe("pad_bot",      15, 271, GREEN, 0);
        probe("pad_above",     8, 207, BLACK, 0);
        probe("pad_below",     8, 272, BLACK, 0);
        probe("pad_right",    16, 208, BLACK, 0);
        probe("pad_left",      7, 208, BLACK, 0);
        probe("origin",        0,   0, BLACK, 0);
        probe("offscreen_h", 700, 100, BLACK, 0);

        // Serve: pending until the frame boundary, then 3 frames of motion.
        press_serve();
        check_ball("serve_pending", 316, 236, BLACK, 0);
        run_to(3);
        check_ball("serve_3f", 322, 242, BLACK, 0);
        probe("serve_origin", 0, 0, BLACK, 0);

        // Bottom, right wall and top bounces.
        run_to(117);  check_ball("pre_bottom", 550, 470, BLACK, 0);
        run_to(118);  check_ball("post_bottom", 552, 468, BLACK, 0);
        run_to(157);  check_ball("pre_right", 630, 390, BLACK, 0);
        run_to(158);  check_ball("post_right", 628, 388, BLACK, 0);
        run_to(351);  check_ball("pre_top", 242, 2, BLACK, 0);
        run_to(352);  check_ball("post_top", 240, 4, BLACK, 0);

        // Paddle hit at the paddle face.
        run_to(464);
        check_ball("pre_hit", 16, 228, BLACK, 0);
        probe("hit_pad_edge", 15, 228, GREEN, 0);
        run_to(465);
        check_ball("post_hit", 18, 230, BLACK, 1);

        // Paddle buttons: up clamps at 0, both hold, down then up.
        btn_up = 1'b1;
        run_to(475);
        probe("up10_top",   8, 168, GREEN, 1);
        probe("up10_above", 8, 167, BLACK, 1);
        run_to(525);
        probe("up60_top",   8,  0, GREEN, 1);
        probe("up60_bot",  15, 63, GREEN, 1);
        probe("up60_below", 8, 64, BLACK, 1);
        btn_down = 1'b1;
        run_to(530);
        probe("both_top",   8,  0, GREEN, 1);
        probe("both_below", 8, 64, BLACK, 1);
        btn_up = 1'b0;
        run_to(533);
        probe("down3_top",   8, 12, GREEN, 1);
        probe("down3_above", 8, 11, BLACK, 1);
        probe("down3_bot",  15, 75, GREEN, 1);
        probe("down3_below", 8, 76, BLACK, 1);
        btn_down = 1'b0;
        btn_up   = 1'b1;
        run_to(536);
        probe("up3_top",   8,  0, GREEN, 1);
        probe("up3_below", 8, 64, BLACK, 1);
        btn_up = 1'b0;

        // Second lap, then a miss with the paddle parked at the top.
        run_to(585);  check_ball("lap2_bottom", 258, 470, BLACK, 1);
        run_to(771);  check_ball("lap2_right", 630, 98, BLACK, 1);
        run_to(819);  check_ball("lap2_top", 534, 2, BLACK, 1);
        run_to(1053); check_ball("lap2_bottom2", 66, 470, BLACK, 1);
        run_to(1078); check_ball("no_overlap_face", 16, 420, BLACK, 1);
        run_to(1079); check_ball("passes_paddle", 14, 418, BLACK, 1);
        run_to(1085); check_ball("pre_miss", 2, 406, BLACK, 1);

        run_to(1086);
        check_ball("miss_frozen", 2, 406, RED, 1);
        probe("miss_bg",        300, 300, RED,   1);
        probe("miss_pad",         8,   0, GREEN, 1);
        probe("miss_offscreen", 700, 100, BLACK, 1);
        probe("miss_blank_row", 100, 480, BLACK, 1);
        run_to(1115);
        probe("miss_last_bg", 300, 300, RED, 1);
        check_ball("miss_last", 2, 406, RED, 1);
        run_to(1116);
        probe("restart_bg", 300, 300, BLACK, 0);
        check_ball("restart", 316, 236, BLACK, 0);
        run_to(1117);
        check_ball("serve_hold", 316, 236, BLACK, 0);

        // Serve again, then reset in the middle of a line.
        press_serve();
        run_to(1119);
        check_ball("reserve_2f", 320, 240, BLACK, 0);
        @(negedge clk);
        hc = 13'(320 * 4);
        vc = 11'd240;
        @(negedge clk);
        check("pre_reset_pixel", {hits, rout, gout, bout}, {8'd0, WHITE});
        #1 rst = 1'b1;
        #1 check("reset_midline", {hits, rout, gout, bout}, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hc  = 13'd0;
        vc  = 11'd500;
        check_ball("after_reset", 316, 236, BLACK, 0);
        probe("after_reset_pad",   8, 208, GREEN, 0);
        probe("after_reset_above", 8, 207, BLACK, 0);

        // Drain the scoreboard.
        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
